// File: rtl/divisible_by_n.sv
// divisible_by_n: serial MSB-first checker reporting whether the bits seen since reset form a multiple of N.
// Define DIVISIBLE_N_ASSERT_EN to compile in simulation-only input, range and shadow-model checks.
module divisible_by_n #(
  parameter int N = 5,
  localparam int W = (N > 2) ? $clog2(N) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out
);
  if (N < 1 || N > 65535) begin : g_bad_n
    $fatal(1, "divisible_by_n: N=%0d outside 1..65535", N);
  end
  localparam logic [W+1:0] NT = (W+2)'(N);
  logic [W-1:0] rem_q, rem_d;
  logic [W+1:0] t;
  // t < 2N, so a single conditional subtract keeps the remainder in 0..N-1
  always_comb begin
    t = {1'b0, rem_q, in};
    rem_d = (t >= NT) ? W'(t - NT) : W'(t);
  end
  always_ff @(posedge clk) rem_q <= rst ? '0 : rem_d;
  assign out = (rem_q == '0);
`ifdef DIVISIBLE_N_ASSERT_EN
  localparam int unsigned NU = N;
  int unsigned shadow_q;
  logic live_q;
  always_ff @(posedge clk) begin
    live_q <= live_q | rst;
    shadow_q <= rst ? 0 : (shadow_q * 2 + 32'(in)) % NU;
    if (!rst && $isunknown(in)) $error("divisible_by_n: in is X/Z");
    if (live_q && 32'(rem_q) >= NU) $error("divisible_by_n: rem %0d >= N", rem_q);
    if (live_q && 32'(rem_q) != shadow_q) $error("divisible_by_n: rem %0d != shadow %0d", rem_q, shadow_q);
  end
`endif
endmodule

// File: tb/tb_divisible_by_n.sv
// tb_divisible_by_n: directed plus random serial streams on five divisors against an arithmetic model.
module tb_divisible_by_n;
  logic clk = 0, rst = 1, in = 0;
  logic o1, o3, o5, o7, o8;
  int n_checks = 0, n_errors = 0;
  int ns[5] = '{1, 3, 5, 7, 8};
  int r[5] = '{0, 0, 0, 0, 0};
  logic [2:0] hist = '0;
  always #5 clk = ~clk;
  divisible_by_n #(.N(1)) u1 (.clk(clk), .rst(rst), .in(in), .out(o1));
  divisible_by_n #(.N(3)) u3 (.clk(clk), .rst(rst), .in(in), .out(o3));
  divisible_by_n #(.N(5)) u5 (.clk(clk), .rst(rst), .in(in), .out(o5));
  divisible_by_n #(.N(7)) u7 (.clk(clk), .rst(rst), .in(in), .out(o7));
  divisible_by_n #(.N(8)) u8 (.clk(clk), .rst(rst), .in(in), .out(o8));
  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic check_all();
    chk("n1_out", int'(o1), 1);
    chk("n3_out", int'(o3), int'(r[1] == 0));
    chk("n5_out", int'(o5), int'(r[2] == 0));
    chk("n7_out", int'(o7), int'(r[3] == 0));
    chk("n8_out", int'(o8), int'(r[4] == 0));
    chk("n8_tail_zero", int'(o8), int'(hist == 3'b000));
  endtask
  task automatic step(input bit b);
    rst = 0;
    in = b;
    @(posedge clk);
    foreach (r[i]) r[i] = (2 * r[i] + int'(b)) % ns[i];
    hist = {hist[1:0], b};
    #1 check_all();
  endtask
  task automatic reset(input int cyc);
    rst = 1;
    repeat (cyc) begin
      in = ~in;
      @(posedge clk);
      foreach (r[i]) r[i] = 0;
      hist = '0;
      #1 check_all();
      chk("rst_rem5", int'(u5.rem_q), 0);
      chk("rst_rem3", int'(u3.rem_q), 0);
    end
  endtask
  initial begin
    bit b5[5] = '{0, 1, 0, 1, 0};
    bit e5[5] = '{1, 0, 0, 1, 1};
    bit b3[5] = '{1, 1, 0, 0, 1};
    bit e3[5] = '{0, 1, 1, 1, 0};
    int m3[5] = '{1, 0, 0, 0, 1};
    bit b8[7] = '{1, 0, 1, 0, 0, 0, 1};
    bit e8[7] = '{0, 0, 0, 0, 0, 1, 0};
    bit bits;
    #2;
    reset(1);
    foreach (b5[k]) begin
      step(b5[k]);
      chk("dir_n5", int'(o5), int'(e5[k]));
    end
    reset(1);
    foreach (b3[k]) begin
      step(b3[k]);
      chk("dir_n3", int'(o3), int'(e3[k]));
      chk("dir_n3_rem", int'(u3.rem_q), m3[k]);
    end
    reset(1);
    step(1); step(0); step(1);
    chk("mid_n5_before_rst", int'(o5), 1);
    in = 0;
    reset(1);
    chk("mid_n5_in_rst", int'(o5), 1);
    step(1);
    chk("mid_n5_after_rst", int'(o5), 0);
    reset(1);
    foreach (b8[k]) begin
      step(b8[k]);
      chk("dir_n8", int'(o8), int'(e8[k]));
    end
    reset(3);
    for (int k = 0; k < 1000; k++) begin
      bits = 1'($urandom);
      step(bits);
      if ($urandom_range(0, 249) == 0) reset(1);
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
